// File: rtl/sort_engine.sv
// In-place bubble sort over a DEPTH x DATA_W register array, one compare/swap per cycle.
// Load and read ports are shared with the sorter; writes and start are honoured only while idle.
module sort_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              descend,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       swap_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COMPARE  = 2'd1;
  localparam logic [1:0] PASS_END = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_TOP = AW'(DEPTH - 1);

  logic [1:0]        state;
  logic [AW-1:0]     j;
  logic [AW-1:0]     last;
  logic              swapped;
  logic              desc_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     j_nxt;
  logic [DATA_W-1:0] elem_a;
  logic [DATA_W-1:0] elem_b;
  logic              out_of_order;
  logic              pass_more;
  logic              wr_ok;

  always_comb begin
    j_nxt        = j + 1'b1;
    elem_a       = mem[j];
    elem_b       = mem[j_nxt];
    // Strict comparisons keep equal neighbours in place, so the sort is stable.
    out_of_order = desc_q ? (elem_a < elem_b) : (elem_a > elem_b);
    // j < last-1 written as j+1 < last, widened so it cannot wrap.
    pass_more    = ({1'b0, j_nxt} < {1'b0, last});
    wr_ok        = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    rd_data      = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
  end

  assign busy = (state == COMPARE) || (state == PASS_END);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      j        <= '0;
      last     <= '0;
      swapped  <= 1'b0;
      desc_q   <= 1'b0;
      swap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COMPARE;
            desc_q   <= descend;
            j        <= '0;
            last     <= LAST_TOP;
            swapped  <= 1'b0;
            swap_cnt <= '0;
          end
        end
        COMPARE: begin
          if (out_of_order) begin
            swapped <= 1'b1;
            if (swap_cnt != 16'hFFFF) swap_cnt <= swap_cnt + 16'd1;
          end
          if (pass_more) j <= j_nxt;
          else           state <= PASS_END;
        end
        PASS_END: begin
          if (!swapped || last == AW'(1)) begin
            state <= DONE;
          end else begin
            last    <= last - 1'b1;
            j       <= '0;
            swapped <= 1'b0;
            state   <= COMPARE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == IDLE) begin
      if (wr_ok) mem[wr_addr] <= wr_data;
    end else if (state == COMPARE && out_of_order) begin
      mem[j]     <= elem_b;
      mem[j_nxt] <= elem_a;
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: reversed, sorted, descending, duplicate, disturbed and reset-mid-sort runs.
module tb_sort_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       descend;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [15:0] swap_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  sort_engine #(.DATA_W(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .descend  (descend),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v [8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = v[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_array(input string tag, input logic [7:0] v [8]);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), {24'd0, rd_data}, {24'd0, v[i]});
    end
  endtask

  // Starts a sort and counts busy cycles and done pulses; optionally hammers wr_en/start while busy.
  task automatic run_sort(input logic d, input bit disturb, output int nb, output int nd);
    @(negedge clk);
    descend = d;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    nd = 0;
    while (busy && nb < 200) begin
      if (disturb && nb < 20) begin
        wr_en   = 1'b1;
        wr_addr = nb[2:0];
        wr_data = 8'hAA;
        start   = 1'b1;
        descend = ~d;
      end else begin
        wr_en   = 1'b0;
        start   = 1'b0;
        descend = d;
      end
      nb++;
      @(negedge clk);
      if (done) nd++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  logic [7:0] v_rev  [8];
  logic [7:0] v_inc  [8];
  logic [7:0] v_zero [8];
  logic [7:0] v_dup  [8];
  logic [7:0] v_dups [8];
  int nb, nd;

  initial begin
    for (int i = 0; i < 8; i++) begin
      v_rev[i]  = 8'(7 - i);
      v_inc[i]  = 8'(i);
      v_zero[i] = 8'd0;
    end
    v_dup  = '{8'd3, 8'd1, 8'd3, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
    v_dups = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};

    rst_n = 1'b0; start = 1'b0; descend = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_swap", {16'd0, swap_cnt}, 32'd0);
    check_array("rst_mem", v_zero);
    @(negedge clk);
    rst_n = 1'b1;

    // Reversed input, ascending
    load(v_rev);
    run_sort(1'b0, 1'b0, nb, nd);
    check("rev_busy_cycles", nb, 35);
    check("rev_done_pulses", nd, 1);
    check("rev_swap", {16'd0, swap_cnt}, 28);
    check_array("rev_mem", v_inc);
    repeat (3) @(negedge clk);
    check("rev_swap_hold", {16'd0, swap_cnt}, 28);

    // Already sorted
    load(v_inc);
    run_sort(1'b0, 1'b0, nb, nd);
    check("sorted_busy_cycles", nb, 8);
    check("sorted_done_pulses", nd, 1);
    check("sorted_swap", {16'd0, swap_cnt}, 0);
    check_array("sorted_mem", v_inc);

    // Descending
    load(v_inc);
    run_sort(1'b1, 1'b0, nb, nd);
    check("desc_busy_cycles", nb, 35);
    check("desc_swap", {16'd0, swap_cnt}, 28);
    check_array("desc_mem", v_rev);

    // Duplicates: 19 strict inversions, equal pairs never exchanged
    load(v_dup);
    run_sort(1'b0, 1'b0, nb, nd);
    check("dup_done_pulses", nd, 1);
    check("dup_swap", {16'd0, swap_cnt}, 19);
    check_array("dup_mem", v_dups);

    // Writes, start and descend toggling while busy must be ignored
    load(v_rev);
    run_sort(1'b0, 1'b1, nb, nd);
    check("dist_busy_cycles", nb, 35);
    check("dist_done_pulses", nd, 1);
    check("dist_swap", {16'd0, swap_cnt}, 28);
    check_array("dist_mem", v_inc);

    // Reset in cycle 10 of a reversed sort
    load(v_rev);
    @(negedge clk);
    descend = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_swap", {16'd0, swap_cnt}, 32'd0);
    check_array("mid_rst_mem", v_zero);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    check("mid_post_quiet", nd, 0);
    check_array("mid_post_mem", v_zero);
    load(v_rev);
    run_sort(1'b0, 1'b0, nb, nd);
    check("mid_resort_busy", nb, 35);
    check("mid_resort_done", nd, 1);
    check("mid_resort_swap", {16'd0, swap_cnt}, 28);
    check_array("mid_resort_mem", v_inc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_engine.md
SORT_ENGINE -- requirements
Module: sort_engine

Interface
REQ-001 Parameter DATA_W, default 8: element width in bits, unsigned, at least 1.
REQ-002 Parameter DEPTH, default 8: number of elements, at least 2; AW = $clog2(DEPTH).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request to sort; sampled only in IDLE.
REQ-006 descend  in  1  0 = ascending, 1 = descending; latched when start is accepted.
REQ-007 wr_en  in  1  load-port write strobe.
REQ-008 wr_addr  in  AW  load-port element index.
REQ-009 wr_data  in  DATA_W  load-port element value.
REQ-010 rd_addr  in  AW  read-port element index.
REQ-011 rd_data  out  DATA_W  combinational read of element rd_addr.
REQ-012 busy  out  1  high while a sort is in progress.
REQ-013 done  out  1  one-cycle pulse when a sort completes.
REQ-014 swap_cnt  out  16  swaps performed by the current or most recent sort; saturates at 16'hFFFF.

Function
REQ-015 Internal storage: DEPTH x DATA_W register array; compare/swap datapath with one read pair and one write pair per cycle.
REQ-016 FSM states: IDLE, COMPARE, PASS_END, DONE.
REQ-017 IDLE to COMPARE:
- on start=1.
- Latch descend.
- Set j=0, last=DEPTH-1, swapped=0, swap_cnt=0.
REQ-018 In IDLE, wr_en=1 writes wr_data to element wr_addr; wr_addr >= DEPTH is ignored.
REQ-019 Outside IDLE, wr_en is ignored, and start is ignored.
REQ-020 COMPARE handles one pair per cycle, elements j and j+1, with an out-of-order test:
- Ascending: out of order when mem[j] > mem[j+1].
- Descending: out of order when mem[j] < mem[j+1].
REQ-021 When a pair is out of order, both elements are exchanged at the same clock edge, swapped is set to 1, and swap_cnt is incremented.
REQ-022 Equal elements are never swapped, so the sort is stable.
REQ-023 COMPARE: if j < last-1 then j increments and the FSM stays in COMPARE; otherwise it goes to PASS_END.
REQ-024 PASS_END lasts one cycle:
- If swapped=0 or last=1, go to DONE.
- Otherwise last decrements, j=0, swapped=0, and the FSM returns to COMPARE.
REQ-025 DONE lasts one cycle (done=1) and then goes to IDLE.
REQ-026 busy=1 exactly in COMPARE and PASS_END; done=1 only in DONE.
REQ-027 A pass with bound L costs L COMPARE cycles plus 1 PASS_END cycle.
- Worst case: DEPTH*(DEPTH-1)/2 + DEPTH-1 busy cycles.
- Already-sorted input: DEPTH busy cycles.
REQ-028 rd_data is valid at all times; during busy it reflects intermediate contents.
REQ-029 swap_cnt holds its value in IDLE until the next accepted start clears it.

Reset
REQ-030 On rst_n=0 the block enters IDLE immediately, regardless of the current state:
- busy=0, done=0, swap_cnt=0, j=0, last=0, swapped=0.
- All array elements are cleared to 0.
REQ-031 Reset asserted mid-sort abandons the sort with no done pulse; after release the array reads all zeros.

Verification
REQ-032 DEPTH=8, DATA_W=8, ascending.
- Stimulus: load 7,6,5,4,3,2,1,0, then start.
- Response: busy high 35 cycles, then done for 1 cycle; array reads 0..7; swap_cnt=28.
REQ-033 Already sorted input.
- Stimulus: load 0..7 ascending, then start.
- Response: busy 8 cycles, then done; swap_cnt=0; array unchanged.
REQ-034 Descending mode.
- Stimulus: load 0..7, start with descend=1.
- Response: array reads 7..0; swap_cnt=28; busy 35 cycles.
REQ-035 Duplicates.
- Stimulus: load 3,1,3,1,2,2,0,0 ascending.
- Response: array reads 0,0,1,1,2,2,3,3; no swaps between equal neighbours.
REQ-036 Writes and start during a sort.
- Stimulus: assert wr_en and start while busy.
- Response: array contents and sort result are unaffected; exactly one done pulse.
REQ-037 Reset mid-sort.
- Stimulus: assert rst_n=0 in cycle 10 of the REQ-032 sort.
- Response: busy=0 and done=0 immediately; all elements read 0; a new load and sort then completes correctly.
